// File: rtl/ring_pkg.sv
// rtl/ring_pkg.sv - shared state encoding and error-counter width for the ring decoder
package ring_pkg;

    typedef enum logic [1:0] {
        SEARCH = 2'd0,
        TRACK  = 2'd1,
        LOCKED = 2'd2
    } state_t;

    localparam int ERR_CNT_W = 8;

endpackage

// File: rtl/onehot_to_bin.sv
// rtl/onehot_to_bin.sv - combinational one-hot check and binary position encoder
module onehot_to_bin #(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH-1:0]         vec,
    output logic                     is_onehot,
    output logic [$clog2(WIDTH)-1:0] index
);

    localparam int IW = $clog2(WIDTH);

    logic [1:0] ones;

    // ones saturates at 2: only "none", "exactly one" and "more than one" matter
    always_comb begin
        ones  = 2'd0;
        index = '0;
        for (int i = 0; i < WIDTH; i++) begin
            if (vec[i]) begin
                index = index | IW'(i);
                if (ones != 2'd2) begin
                    ones = ones + 2'd1;
                end
            end
        end
        is_onehot = (ones == 2'd1);
    end

endmodule

// File: rtl/ring_decoder.sv
// rtl/ring_decoder.sv - ring-counter decoder with sequence lock and error pulse
// Optional error counter enabled by RING_DECODER_ERR_COUNT_EN.
module ring_decoder
    import ring_pkg::*;
#(
    parameter int WIDTH      = 4,
    parameter int LOCK_COUNT = 3
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     in_valid,
    input  logic [WIDTH-1:0]         ring_in,
    output logic [$clog2(WIDTH)-1:0] index,
    output logic                     index_valid,
    output logic                     locked,
    output logic                     err,
    output logic [ERR_CNT_W-1:0]     err_count
);

    localparam int IW = $clog2(WIDTH);
    localparam int CW = $clog2(LOCK_COUNT + 1);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] prev_q, prev_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [IW-1:0]    index_q, index_d;
    logic             index_valid_q, index_valid_d;
    logic             err_q, err_d;

    logic             is_onehot;
    logic [IW-1:0]    dec_index;
    logic [WIDTH-1:0] succ;

    onehot_to_bin #(.WIDTH(WIDTH)) u_dec (
        .vec       (ring_in),
        .is_onehot (is_onehot),
        .index     (dec_index)
    );

    assign succ = {prev_q[WIDTH-2:0], prev_q[WIDTH-1]};

    always_comb begin
        state_d       = state_q;
        prev_d        = prev_q;
        cnt_d         = cnt_q;
        index_d       = index_q;
        index_valid_d = 1'b0;
        err_d         = 1'b0;
        if (in_valid) begin
            index_valid_d = is_onehot;
            if (is_onehot) begin
                index_d = dec_index;
            end
            if (state_q == SEARCH) begin
                if (is_onehot) begin
                    prev_d  = ring_in;
                    cnt_d   = CW'(1);
                    state_d = TRACK;
                end
            end else if (ring_in == succ) begin
                prev_d = ring_in;
                if (state_q == TRACK) begin
                    cnt_d = cnt_q + CW'(1);
                    if (cnt_q == CW'(LOCK_COUNT - 1)) begin
                        state_d = LOCKED;
                    end
                end
            end else begin
                // a break only counts as an error once the sequence was confirmed
                err_d = (state_q == LOCKED);
                if (is_onehot) begin
                    prev_d  = ring_in;
                    cnt_d   = CW'(1);
                    state_d = TRACK;
                end else begin
                    cnt_d   = '0;
                    state_d = SEARCH;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= SEARCH;
            prev_q        <= '0;
            cnt_q         <= '0;
            index_q       <= '0;
            index_valid_q <= 1'b0;
            err_q         <= 1'b0;
        end else begin
            state_q       <= state_d;
            prev_q        <= prev_d;
            cnt_q         <= cnt_d;
            index_q       <= index_d;
            index_valid_q <= index_valid_d;
            err_q         <= err_d;
        end
    end

`ifdef RING_DECODER_ERR_COUNT_EN
    logic [ERR_CNT_W-1:0] err_cnt_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            err_cnt_q <= '0;
        end else if (err_d && (err_cnt_q != '1)) begin
            err_cnt_q <= err_cnt_q + ERR_CNT_W'(1);
        end
    end

    assign err_count = err_cnt_q;
`else
    assign err_count = '0;
`endif

    assign index       = index_q;
    assign index_valid = index_valid_q;
    assign locked      = (state_q == LOCKED);
    assign err         = err_q;

endmodule

// File: tb/tb_ring_decoder.sv
// tb/tb_ring_decoder.sv - table-driven self-checking bench for ring_decoder
module tb_ring_decoder;

`ifdef RING_DECODER_ERR_COUNT_EN
    localparam bit EC_EN = 1'b1;
`else
    localparam bit EC_EN = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       in_valid = 1'b0;
    logic [3:0] ring_in = 4'b0000;
    logic [1:0] index;
    logic       index_valid;
    logic       locked;
    logic       err;
    logic [7:0] err_count;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    ring_decoder #(.WIDTH(4), .LOCK_COUNT(3)) dut (
        .clk         (clk),
        .reset       (reset),
        .in_valid    (in_valid),
        .ring_in     (ring_in),
        .index       (index),
        .index_valid (index_valid),
        .locked      (locked),
        .err         (err),
        .err_count   (err_count)
    );

    typedef struct {
        logic       rst;
        logic       v;
        logic [3:0] ring;
        logic [1:0] idx;
        logic       iv;
        logic       lk;
        logic       er;
        logic [7:0] ec;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic rst, input logic v, input logic [3:0] ring,
                       input logic [1:0] idx, input logic iv, input logic lk,
                       input logic er, input logic [7:0] ec);
        vec_t t;
        t.rst = rst; t.v = v; t.ring = ring; t.idx = idx;
        t.iv = iv; t.lk = lk; t.er = er; t.ec = EC_EN ? ec : 8'd0;
        vecs.push_back(t);
    endtask

    task automatic chk(input string name, input int row, input logic [7:0] act,
                       input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s row=%0d actual=%0h expected=%0h", name, row, act, exp);
        end
    endtask

    task automatic step(input logic rst, input logic v, input logic [3:0] ring);
        reset    = rst;
        in_valid = v;
        ring_in  = ring;
        @(posedge clk);
        #1;
    endtask

    initial begin
        int exp_ec;
        //   rst  v     ring     idx  iv lk er ec
        add(1'b1, 1'b0, 4'b0000, 2'd0, 0, 0, 0, 0);   // reset state
        add(1'b0, 1'b1, 4'b0001, 2'd0, 1, 0, 0, 0);
        add(1'b0, 1'b1, 4'b0010, 2'd1, 1, 0, 0, 0);
        add(1'b0, 1'b1, 4'b0100, 2'd2, 1, 1, 0, 0);   // lock on third
        add(1'b0, 1'b1, 4'b0001, 2'd0, 1, 0, 1, 1);   // locked mismatch, reseed
        add(1'b0, 1'b1, 4'b0010, 2'd1, 1, 0, 0, 1);
        add(1'b0, 1'b1, 4'b0100, 2'd2, 1, 1, 0, 1);   // relock
        add(1'b0, 1'b1, 4'b1000, 2'd3, 1, 1, 0, 1);
        add(1'b0, 1'b1, 4'b0001, 2'd0, 1, 1, 0, 1);   // wrap while locked
        add(1'b0, 1'b0, 4'b0011, 2'd0, 0, 1, 0, 1);   // idle holds
        add(1'b0, 1'b1, 4'b0011, 2'd0, 0, 0, 1, 2);   // non-one-hot in LOCKED
        add(1'b0, 1'b1, 4'b0000, 2'd0, 0, 0, 0, 2);   // SEARCH, no err
        add(1'b0, 1'b1, 4'b0011, 2'd0, 0, 0, 0, 2);
        add(1'b0, 1'b1, 4'b0100, 2'd2, 1, 0, 0, 2);   // TRACK
        add(1'b0, 1'b1, 4'b0100, 2'd2, 1, 0, 0, 2);   // TRACK mismatch, no err
        add(1'b0, 1'b1, 4'b1000, 2'd3, 1, 0, 0, 2);
        add(1'b0, 1'b1, 4'b0001, 2'd0, 1, 1, 0, 2);   // lock across wrap
        add(1'b1, 1'b1, 4'b0010, 2'd0, 0, 0, 0, 0);   // reset beats in_valid
        add(1'b0, 1'b1, 4'b1000, 2'd3, 1, 0, 0, 0);
        add(1'b0, 1'b1, 4'b0001, 2'd0, 1, 0, 0, 0);
        add(1'b0, 1'b1, 4'b0010, 2'd1, 1, 1, 0, 0);
        add(1'b0, 1'b0, 4'b0000, 2'd1, 0, 1, 0, 0);
        add(1'b1, 1'b0, 4'b0000, 2'd0, 0, 0, 0, 0);   // alternating valid
        add(1'b0, 1'b1, 4'b0001, 2'd0, 1, 0, 0, 0);
        add(1'b0, 1'b0, 4'b0010, 2'd0, 0, 0, 0, 0);
        add(1'b0, 1'b1, 4'b0010, 2'd1, 1, 0, 0, 0);
        add(1'b0, 1'b0, 4'b0100, 2'd1, 0, 0, 0, 0);
        add(1'b0, 1'b1, 4'b0100, 2'd2, 1, 1, 0, 0);
        add(1'b0, 1'b0, 4'b0000, 2'd2, 0, 1, 0, 0);

        for (int r = 0; r < vecs.size(); r++) begin
            step(vecs[r].rst, vecs[r].v, vecs[r].ring);
            chk("index",       r, {6'd0, index},       {6'd0, vecs[r].idx});
            chk("index_valid", r, {7'd0, index_valid}, {7'd0, vecs[r].iv});
            chk("locked",      r, {7'd0, locked},      {7'd0, vecs[r].lk});
            chk("err",         r, {7'd0, err},         {7'd0, vecs[r].er});
            chk("err_count",   r, err_count,           vecs[r].ec);
        end

        // 260 locked mismatches from LOCKED with prev=0100; counter saturates
        exp_ec = 0;
        for (int k = 1; k <= 260; k++) begin
            step(1'b0, 1'b1, 4'b0001);
            if (exp_ec < 255) exp_ec++;
            chk("sat_err_pulse", k, {7'd0, err}, 8'd1);
            chk("sat_err_count", k, err_count, EC_EN ? 8'(exp_ec) : 8'd0);
            step(1'b0, 1'b1, 4'b0010);
            chk("sat_err_clear", k, {7'd0, err}, 8'd0);
            step(1'b0, 1'b1, 4'b0100);
            chk("sat_relock", k, {7'd0, locked}, 8'd1);
        end
        chk("sat_final", 260, err_count, EC_EN ? 8'd255 : 8'd0);

        step(1'b1, 1'b0, 4'b0000);
        chk("reset_err_count", 0, err_count, 8'd0);
        chk("reset_locked", 0, {7'd0, locked}, 8'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/ring_decoder.md
RING_DECODER -- requirements
Module: ring_decoder

Interface
REQ-001 SHALL have parameter WIDTH, default 4, ring length in bits (>=2).
REQ-002 SHALL have parameter LOCK_COUNT, default 3, consecutive correct samples needed for lock (>=2).
REQ-003 SHALL have port clk  input  1  sole clock, all state on rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port in_valid  input  1  ring_in is sampled this cycle.
REQ-006 SHALL have port ring_in  input  WIDTH  one-hot ring pattern from the ring counter.
REQ-007 SHALL have port index  output  clog2(WIDTH)  binary position of the set bit.
REQ-008 SHALL have port index_valid  output  1  index holds a decoded one-hot sample.
REQ-009 SHALL have port locked  output  1  sequence tracked and confirmed.
REQ-010 SHALL have port err  output  1  one-cycle pulse on sequence break while locked.
REQ-011 SHALL have port err_count  output  8  saturating count of err pulses.

Function
REQ-012 SHALL treat a sample as one-hot only when exactly one bit of ring_in is 1.
REQ-013 SHALL define the expected successor as rotate-left by one: bit i goes to bit i+1, bit WIDTH-1 wraps to bit 0.
REQ-014 SHALL register all outputs; a sample taken at edge N appears on the outputs after edge N.
REQ-015 SHALL, per accepted sample, set index_valid=1 and index=set-bit position if one-hot, else index_valid=0 and index unchanged.
REQ-016 SHALL, with in_valid=0, clear index_valid and err and hold state, prev and match_cnt.
REQ-017 SHALL implement states SEARCH, TRACK and LOCKED; locked=1 only in LOCKED.
REQ-018 SEARCH: a one-hot sample sets prev=sample, match_cnt=1 and moves to TRACK; a non-one-hot sample keeps SEARCH with no err.
REQ-019 TRACK: a sample equal to the expected successor of prev sets prev=sample and increments match_cnt; reaching LOCK_COUNT moves to LOCKED.
REQ-020 TRACK/LOCKED mismatch: a one-hot sample re-seeds to TRACK (prev=sample, match_cnt=1); a non-one-hot sample moves to SEARCH.
REQ-021 SHALL pulse err for exactly one cycle only on a mismatch in LOCKED; a mismatch in TRACK raises no err.
REQ-022 SHALL increment err_count on every err and saturate at 255, never wrapping.
REQ-023 LOCKED with a matching sample: SHALL stay LOCKED with prev updated, including across the wrap from bit WIDTH-1 to bit 0.

Reset
REQ-024 With reset high at a clock edge, SHALL set state=SEARCH, prev=0, match_cnt=0, index=0, index_valid=0, locked=0, err=0, err_count=0.
REQ-025 Reset SHALL take priority over in_valid in the same cycle, including mid-TRACK or mid-LOCKED.

Configuration
REQ-026 Macro RING_DECODER_ERR_COUNT_EN defined: err_count SHALL be implemented per REQ-022.
REQ-027 Macro RING_DECODER_ERR_COUNT_EN undefined: err_count SHALL be tied to 0 with no counter flops; err SHALL be unaffected.

Structure
REQ-028 A shared package ring_pkg SHALL hold the state enum (SEARCH/TRACK/LOCKED) and the err_count width constant (8).
REQ-029 SHALL instantiate one sub-module, onehot_to_bin, which is combinational and outputs is_onehot and the binary index.

Verification (WIDTH=4, LOCK_COUNT=3)
REQ-030 Feed 0001,0010,0100 with in_valid=1 -> index 0,1,2 with index_valid=1; locked=1 after the third sample; err=0.
REQ-031 When locked after 0100, feed 0001 (expected 1000) -> err=1 for one cycle, err_count=1, locked=0, state TRACK; then 0010,0100 -> locked=1 again.
REQ-032 Feed 0011 or 0000 in SEARCH -> index_valid=0, err=0, state stays SEARCH; feed 0011 in LOCKED -> err pulse, state SEARCH.
REQ-033 Lock, then assert reset for one cycle mid-sequence -> all outputs 0 next cycle and err_count=0; deassert and feed 1000,0001,0010 -> locked (wrap case).
REQ-034 Alternate in_valid 1/0 over 0001,0010,0100 -> index_valid 1/0 alternating, locked after the third valid sample.
REQ-035 Force 260 locked-mismatch events -> err_count holds at 255; with RING_DECODER_ERR_COUNT_EN undefined -> err_count stays 0 and err pulses are unchanged.
